// File: rtl/data_mem_ctrl_pkg.sv
// Shared types and defaults for the MEM-stage data-memory access controller.
package mem_ctrl_pkg;

  // Controller states: accept, strobe memory, wait for completion, respond.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } mc_state_t;

  localparam logic MC_ERR_NONE  = 1'b0;
  localparam logic MC_ERR_FAULT = 1'b1;

  localparam int MC_DATA_W    = 16;
  localparam int MC_ADDR_W    = 16;
  localparam int MC_OFF_W     = 4;
  localparam int MC_OFF_SHIFT = 1;
  localparam int MC_TIMEOUT   = 15;

endpackage

// File: rtl/data_mem_ctrl_addr_gen.sv
// Effective-address generator: base + (sign-extended offset << OFF_SHIFT),
// wrapping modulo 2^ADDR_W, plus a check of the low alignment bits.
// Kept free of controller state so the fetch-stage branch-target path can reuse it.
module mem_addr_gen #(
  parameter int ADDR_W    = 16,
  parameter int OFF_W     = 4,
  parameter int OFF_SHIFT = 1
) (
  input  logic [ADDR_W-1:0] base,
  input  logic [OFF_W-1:0]  offset,
  output logic [ADDR_W-1:0] target,
  output logic              misaligned
);

  logic [ADDR_W-1:0] off_ext_s;

  // Sign-extend and scale the offset, then add to the base (carry out discarded).
  always_comb begin
    off_ext_s = ADDR_W'($signed(offset));
    target    = base + (off_ext_s << OFF_SHIFT);
  end

  // With no scaling every address is legal; otherwise the low bits must be zero.
  if (OFF_SHIFT == 0) begin : g_no_align
    assign misaligned = 1'b0;
  end else begin : g_align
    assign misaligned = |target[OFF_SHIFT-1:0];
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// MEM-stage data-memory access controller: one access at a time over an
// enable/valid handshake, with misalignment fault and wait timeout.
module data_mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int DATA_W    = MC_DATA_W,
  parameter int ADDR_W    = MC_ADDR_W,
  parameter int OFF_W     = MC_OFF_W,
  parameter int OFF_SHIFT = MC_OFF_SHIFT,
  parameter int TIMEOUT   = MC_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] base,
  input  logic [DATA_W-1:0] wdata,
  input  logic [OFF_W-1:0]  offset,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              stall,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_valid
);

  // Counter must be able to hold TIMEOUT itself.
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  mc_state_t         state_r, state_next_s;
  logic [CNT_W-1:0]  cnt_r, cnt_next_s, cnt_inc_s;
  logic [ADDR_W-1:0] target_s;
  logic              misaligned_s;
  logic              accept_s;

  logic              mem_en_r, mem_en_next_s;
  logic              mem_wr_r, mem_wr_next_s;
  logic [ADDR_W-1:0] mem_addr_r, mem_addr_next_s;
  logic [DATA_W-1:0] mem_wdata_r, mem_wdata_next_s;
  logic              resp_valid_r, resp_valid_next_s;
  logic [DATA_W-1:0] resp_rdata_r, resp_rdata_next_s;
  logic              resp_err_r, resp_err_next_s;

  mem_addr_gen #(
    .ADDR_W    (ADDR_W),
    .OFF_W     (OFF_W),
    .OFF_SHIFT (OFF_SHIFT)
  ) u_addr_gen (
    .base       (base),
    .offset     (offset),
    .target     (target_s),
    .misaligned (misaligned_s)
  );

  assign req_ready  = (state_r == IDLE);
  assign accept_s   = req_valid && req_ready;
  assign stall      = req_valid && ((state_r != IDLE) || accept_s);
  assign cnt_inc_s  = cnt_r + CNT_W'(1);

  assign mem_en     = mem_en_r;
  assign mem_wr     = mem_wr_r;
  assign mem_addr   = mem_addr_r;
  assign mem_wdata  = mem_wdata_r;
  assign resp_valid = resp_valid_r;
  assign resp_rdata = resp_rdata_r;
  assign resp_err   = resp_err_r;

  // Next-state and next-output decode; strobes default low, data holds.
  always_comb begin
    state_next_s      = state_r;
    cnt_next_s        = cnt_r;
    mem_en_next_s     = 1'b0;
    mem_wr_next_s     = mem_wr_r;
    mem_addr_next_s   = mem_addr_r;
    mem_wdata_next_s  = mem_wdata_r;
    resp_valid_next_s = 1'b0;
    resp_rdata_next_s = resp_rdata_r;
    resp_err_next_s   = resp_err_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          mem_wr_next_s    = req_wr;
          mem_addr_next_s  = target_s;
          mem_wdata_next_s = wdata;
          if (misaligned_s) begin
            state_next_s      = RESP;
            resp_valid_next_s = 1'b1;
            resp_err_next_s   = MC_ERR_FAULT;
            resp_rdata_next_s = {DATA_W{1'b0}};
          end else begin
            state_next_s  = ISSUE;
            mem_en_next_s = 1'b1;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      ISSUE: begin
        state_next_s = WAIT;
        cnt_next_s   = {CNT_W{1'b0}};
      end
      WAIT: begin
        cnt_next_s = cnt_inc_s;
        // Completion wins over timeout when both land in the same cycle.
        if (mem_valid) begin
          state_next_s      = RESP;
          resp_valid_next_s = 1'b1;
          resp_err_next_s   = MC_ERR_NONE;
          resp_rdata_next_s = mem_wr_r ? {DATA_W{1'b0}} : mem_rdata;
        end else if (cnt_inc_s == CNT_W'(TIMEOUT)) begin
          state_next_s      = RESP;
          resp_valid_next_s = 1'b1;
          resp_err_next_s   = MC_ERR_FAULT;
          resp_rdata_next_s = {DATA_W{1'b0}};
        end else begin
          state_next_s = WAIT;
        end
      end
      RESP: begin
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State register; reset abandons any in-flight access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Wait counter and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r        <= {CNT_W{1'b0}};
      mem_en_r     <= 1'b0;
      mem_wr_r     <= 1'b0;
      mem_addr_r   <= {ADDR_W{1'b0}};
      mem_wdata_r  <= {DATA_W{1'b0}};
      resp_valid_r <= 1'b0;
      resp_rdata_r <= {DATA_W{1'b0}};
      resp_err_r   <= 1'b0;
    end else begin
      cnt_r        <= cnt_next_s;
      mem_en_r     <= mem_en_next_s;
      mem_wr_r     <= mem_wr_next_s;
      mem_addr_r   <= mem_addr_next_s;
      mem_wdata_r  <= mem_wdata_next_s;
      resp_valid_r <= resp_valid_next_s;
      resp_rdata_r <= resp_rdata_next_s;
      resp_err_r   <= resp_err_next_s;
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: directed scenarios plus randomized
// transactions checked against a transaction-level reference model.
module tb_data_mem_ctrl;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wr = 1'b0;
  logic [15:0] base = 16'h0;
  logic [15:0] wdata = 16'h0;
  logic [3:0]  offset = 4'h0;
  logic        resp_valid;
  logic [15:0] resp_rdata;
  logic        resp_err;
  logic        stall;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = 16'h0;
  logic        mem_valid = 1'b0;

  int checks = 0;
  int errors = 0;

  // Memory contents seen by the bench; unwritten words read as addr ^ 16'h5A5A.
  logic [15:0] mem_model [int];

  data_mem_ctrl #(
    .DATA_W(16), .ADDR_W(16), .OFF_W(4), .OFF_SHIFT(1), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .base(base), .wdata(wdata), .offset(offset),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .stall(stall), .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_valid(mem_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Idle cycles with an optional stray mem_valid at index stray; no activity expected.
  task automatic idle(input int n, input int stray);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      req_valid = 1'b0;
      mem_valid = (i == stray);
      mem_rdata = 16'($urandom);
      #1;
      check("idle_resp_valid", resp_valid, 0);
      check("idle_mem_en", mem_en, 0);
      check("idle_req_ready", req_ready, 1);
      check("idle_stall", stall, 0);
    end
  endtask

  // One transaction. lat = cycles from mem_en to mem_valid (0 = memory never answers).
  // hold keeps req_valid high (with junk fields) while busy. stop_at truncates the run.
  task automatic txn(input bit wr, input logic [15:0] b, input logic [3:0] o,
                     input logic [15:0] wd, input int lat, input bit hold, input int stop_at);
    int          off_i;
    logic [15:0] tgt;
    bit          mis;
    int          rc;
    bit          e_err;
    logic [15:0] e_rd;
    logic [15:0] ld;
    off_i = (o > 4'd7) ? int'(o) - 16 : int'(o);
    tgt   = 16'(int'(b) + off_i * 2);
    mis   = (tgt % 16'd2) != 16'd0;
    ld    = mem_model.exists(int'(tgt)) ? mem_model[int'(tgt)] : (tgt ^ 16'h5A5A);
    if (mis) begin
      rc = 1; e_err = 1'b1; e_rd = 16'h0;
    end else if (lat >= 1 && lat <= TO) begin
      rc = lat + 2; e_err = 1'b0; e_rd = wr ? 16'h0 : ld;
    end else begin
      rc = TO + 2; e_err = 1'b1; e_rd = 16'h0;
    end
    @(negedge clk);
    req_valid = 1'b1; req_wr = wr; base = b; offset = o; wdata = wd;
    mem_valid = 1'b0; mem_rdata = 16'($urandom);
    #1;
    check("c0_req_ready", req_ready, 1);
    check("c0_stall", stall, 1);
    check("c0_mem_en", mem_en, 0);
    check("c0_resp_valid", resp_valid, 0);
    for (int c = 1; c <= rc && c <= stop_at; c++) begin
      @(negedge clk);
      req_valid = hold;
      req_wr = 1'($urandom); base = 16'($urandom); offset = 4'($urandom); wdata = 16'($urandom);
      mem_valid = !mis && lat >= 1 && (c == lat + 1);
      mem_rdata = mem_valid ? ld : 16'($urandom);
      #1;
      check("busy_req_ready", req_ready, 0);
      check("busy_stall", stall, hold);
      check("mem_en", mem_en, (!mis && c == 1));
      if (!mis && c == 1) begin
        check("mem_addr", mem_addr, tgt);
        check("mem_wr", mem_wr, wr);
        check("mem_wdata", mem_wdata, wd);
      end
      check("resp_valid", resp_valid, (c == rc));
      if (c == rc) begin
        check("resp_rdata", resp_rdata, e_rd);
        check("resp_err", resp_err, e_err);
      end
    end
    if (!mis && wr && lat >= 1 && lat <= TO && stop_at >= rc) mem_model[int'(tgt)] = wd;
  endtask

  initial begin
    bit          r_wr;
    logic [15:0] r_b;
    logic [3:0]  r_o;
    int          r_sel;
    int          r_lat;

    // Reset state
    #1;
    check("rst_req_ready", req_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_stall", stall, 0);
    check("rst_mem_addr", mem_addr, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Aligned load with latency 4, pipeline holding req_valid
    mem_model[int'(16'h000E)] = 16'hBEEF;
    txn(1'b0, 16'h0010, 4'hF, 16'h0000, 4, 1'b1, 99);
    // Store wrapping past the top of the address space, 1-cycle ack
    txn(1'b1, 16'hFFFE, 4'h2, 16'h1234, 1, 1'b0, 99);
    // Misaligned: fault at cycle 1, no mem_en
    txn(1'b0, 16'h0011, 4'h0, 16'h0000, 2, 1'b0, 99);
    // Timeout, then a late mem_valid at cycle 20 is ignored
    txn(1'b0, 16'h0040, 4'h1, 16'h0000, 0, 1'b0, 99);
    idle(5, 2);
    // mem_valid on the last WAIT cycle wins; held req not accepted until after RESP
    txn(1'b0, 16'h0080, 4'h3, 16'h0000, TO, 1'b1, 99);
    // mem_valid arriving in the RESP cycle is too late: timeout
    txn(1'b0, 16'h0090, 4'h0, 16'h0000, TO + 1, 1'b0, 99);
    // Store then load the same word via different base/offset
    txn(1'b1, 16'h01FC, 4'h2, 16'hCAFE, 2, 1'b0, 99);
    txn(1'b0, 16'h0204, 4'hE, 16'h0000, 3, 1'b0, 99);

    // Reset asserted mid-cycle while waiting on memory
    txn(1'b0, 16'h0100, 4'h2, 16'h0000, 0, 1'b0, 5);
    #2 rst = 1'b0;
    #1;
    check("arst_req_ready", req_ready, 1);
    check("arst_stall", stall, 0);
    check("arst_resp_valid", resp_valid, 0);
    check("arst_resp_err", resp_err, 0);
    check("arst_resp_rdata", resp_rdata, 0);
    check("arst_mem_en", mem_en, 0);
    check("arst_mem_wr", mem_wr, 0);
    check("arst_mem_addr", mem_addr, 0);
    check("arst_mem_wdata", mem_wdata, 0);
    @(negedge clk);
    rst = 1'b1;
    idle(3, 0);
    txn(1'b0, 16'h0100, 4'h2, 16'h0000, 2, 1'b0, 99);

    // Randomized transactions
    for (int i = 0; i < 30; i++) begin
      r_wr = 1'($urandom);
      r_b  = 16'($urandom);
      if ($urandom_range(0, 3) != 0) r_b[0] = 1'b0;
      r_o   = 4'($urandom);
      r_sel = $urandom_range(0, 9);
      r_lat = (r_sel < 7) ? $urandom_range(1, 6) : ((r_sel == 7) ? TO : ((r_sel == 8) ? TO + 1 : 0));
      txn(r_wr, r_b, r_o, 16'($urandom), r_lat, (i < 29) ? 1'($urandom) : 1'b0, 99);
    end
    idle(2, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Parametrised data-memory access controller for the MEM stage of the 16-bit pipeline. It forms the effective address as base register plus scaled, sign-extended offset, and drives one access at a time into a multi-cycle data memory over an enable/valid handshake. It returns a response and holds the pipeline stalled until the access completes, faults (misaligned) or times out.

## Interface
Parameters:
- `DATA_W`, 16: data width.
- `ADDR_W`, 16: address width.
- `OFF_W`, 4: offset field width; signed.
- `OFF_SHIFT`, 1: left shift applied to the offset; also the alignment requirement (low `OFF_SHIFT` address bits must be 0).
- `TIMEOUT`, 15: maximum WAIT cycles before a fault; ≥1.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `req_valid` in 1: pipeline requests an access.
- `req_ready` out 1: controller can accept a request (IDLE).
- `req_wr` in 1: 1 = store, 0 = load.
- `base` in ADDR_W: base register value (rs).
- `wdata` in DATA_W: store data (rt).
- `offset` in OFF_W: signed offset field.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out DATA_W: load data; 0 for stores and faults.
- `resp_err` out 1: fault flag, qualified by `resp_valid`.
- `stall` out 1: pipeline hold.
- `mem_en` out 1: one-cycle memory request strobe.
- `mem_wr` out 1: memory write enable.
- `mem_addr` out ADDR_W: memory address.
- `mem_wdata` out DATA_W: memory write data.
- `mem_rdata` in DATA_W: memory read data, valid with `mem_valid`.
- `mem_valid` in 1: memory completion, for both read and write.

## Operation
- Effective address: `target = base + (sext(offset) << OFF_SHIFT)`, truncated to ADDR_W. Wraps modulo 2^ADDR_W with no fault.
- A request is accepted when `req_valid && req_ready`. On acceptance the controller registers `target`, `wdata` and `req_wr`. Request inputs are ignored in every other cycle.
- Misaligned: any of `target[OFF_SHIFT-1:0]` nonzero (never when OFF_SHIFT=0). The request goes IDLE→RESP with `resp_err=1`, `resp_rdata=0`, and no `mem_en`.
- States:
  - IDLE: `req_ready=1`. On an aligned accept → ISSUE; on a misaligned accept → RESP.
  - ISSUE: `mem_en=1` for exactly one cycle; `mem_wr`, `mem_addr`, `mem_wdata` come from the registered values. → WAIT, with the wait counter cleared.
  - WAIT: the counter increments each cycle.
    - If `mem_valid`: capture `mem_rdata` for loads (0 for stores) and set err=0 → RESP.
    - Else, if the counter reaches TIMEOUT: set err=1 and rdata=0 → RESP.
    - `mem_valid` takes priority over timeout in the same cycle.
  - RESP: `resp_valid=1` for one cycle → IDLE.
- `stall = req_valid && (state != IDLE || accepting)`. The pipeline is held from the accept cycle through the RESP cycle and released the cycle after RESP.
- `mem_valid` outside WAIT is ignored.
- `mem_addr`, `mem_wdata` and `mem_wr` hold their registered values outside ISSUE. They are only meaningful when `mem_en` is high.
- Reset, asynchronous and at any time:
  - State returns to IDLE.
  - All registers and outputs clear: `req_ready=1`, every other output 0.
  - An in-flight access is abandoned, and a late `mem_valid` after reset is ignored (state is IDLE).

## Timing
- Accept in cycle 0 → `mem_en` in cycle 1 → earliest `mem_valid` in cycle 2 → `resp_valid` in the cycle after `mem_valid`.
- Aligned latency, accept to `resp_valid`: L + 2 cycles, where L is the number of cycles from `mem_en` to `mem_valid` (L ≥ 1).
- Misaligned: `resp_valid` in cycle 1.
- Timeout: `resp_valid` in cycle TIMEOUT + 2 after accept.
- Back-to-back throughput: next accept no earlier than the cycle after RESP.
- All outputs are registered except `req_ready` and `stall`, which are decoded from state and `req_valid`.

## Structure
- Package `mem_ctrl_pkg` holds:
  - the state enum `mc_state_t` {IDLE, ISSUE, WAIT, RESP};
  - constant `MC_ERR_NONE`/`MC_ERR_FAULT`;
  - the default parameter values.
- Sub-module `mem_addr_gen`: combinational adder plus alignment check, parametrised on ADDR_W/OFF_W/OFF_SHIFT. It outputs `target` and `misaligned`, and is reusable by the fetch-stage branch-target path.

## Test plan
- Aligned load, defaults: base=0x0010, offset=4'b1111 (−1) → `mem_addr`=0x000E. Memory latency 4 with rdata=0xBEEF → `resp_valid` at cycle 6, `resp_rdata`=0xBEEF, err=0; `stall` high cycles 0–6.
- Store with wrap: base=0xFFFE, offset=2, wdata=0x1234 → `mem_en`, `mem_wr`=1, `mem_addr`=0x0002, `mem_wdata`=0x1234. Ack after 1 cycle → resp at cycle 3 with rdata=0.
- Misaligned: base=0x0011, offset=0 → `resp_valid`+`resp_err` at cycle 1, `mem_en` never asserted.
- Timeout: memory never asserts valid → `resp_err=1` at cycle 17 (TIMEOUT=15). Then `mem_valid` pulsed at cycle 20 → no response, state IDLE.
- Simultaneous events: `mem_valid` in the same cycle the counter hits TIMEOUT → err=0 and data captured. A `req_valid` held during WAIT is not accepted until the cycle after RESP.
- Reset in WAIT: drive `rst` low asynchronously mid-cycle → outputs clear immediately. After release, a stray `mem_valid` produces no response, and a new request completes normally.
